// File: rtl/mccu_pkg.sv
// Shared constants for the multicycle MIPS control unit: state encodings,
// ALU operation codes, opcode/func/rt fields and the decoded instruction class.
package mccu_pkg;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SLL  = 4'b1110;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_JALR = 6'b001001;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // One-hot instruction class; alu_is sign-extends its immediate, alu_iz zero-extends.
  typedef struct packed {
    logic alu_r;
    logic shift_r;
    logic alu_is;
    logic alu_iz;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic bgez;
    logic bltz;
    logic blez;
    logic bgtz;
    logic j;
    logic jal;
    logic jr;
    logic jalr;
    logic illegal;
  } inst_cls_t;

endpackage

// File: rtl/mccu_decode.sv
// Combinational instruction decoder: IR op/func/rt fields to a one-hot class
// and the ALU operation used in EXE.
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  input  logic [4:0] i_rt,
  output inst_cls_t  o_cls,
  output logic [3:0] o_aluc
);

  always_comb begin
    o_cls  = '0;
    o_aluc = ALUC_ADD;
    case (i_op)
      OP_RTYPE: begin
        case (i_func)
          F_ADD:  begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_ADD;  end
          F_ADDU: begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_ADDU; end
          F_SUB:  begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_SUB;  end
          F_SUBU: begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_SUBU; end
          F_AND:  begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_AND;  end
          F_OR:   begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_OR;   end
          F_XOR:  begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_XOR;  end
          F_NOR:  begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_NOR;  end
          F_SLT:  begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_SLT;  end
          F_SLTU: begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_SLTU; end
          F_SLL:  begin o_cls.shift_r = 1'b1; o_aluc = ALUC_SLL;  end
          F_SRL:  begin o_cls.shift_r = 1'b1; o_aluc = ALUC_SRL;  end
          F_SRA:  begin o_cls.shift_r = 1'b1; o_aluc = ALUC_SRA;  end
          F_SLLV: begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_SLL;  end
          F_SRLV: begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_SRL;  end
          F_SRAV: begin o_cls.alu_r = 1'b1;   o_aluc = ALUC_SRA;  end
          F_JR:   o_cls.jr   = 1'b1;
          F_JALR: o_cls.jalr = 1'b1;
          default: o_cls.illegal = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        o_aluc = ALUC_SUB;
        if (i_rt == RT_BGEZ)      o_cls.bgez    = 1'b1;
        else if (i_rt == RT_BLTZ) o_cls.bltz    = 1'b1;
        else                      o_cls.illegal = 1'b1;
      end
      OP_J:     o_cls.j   = 1'b1;
      OP_JAL:   o_cls.jal = 1'b1;
      OP_BEQ:   begin o_cls.beq  = 1'b1; o_aluc = ALUC_SUB; end
      OP_BNE:   begin o_cls.bne  = 1'b1; o_aluc = ALUC_SUB; end
      OP_BLEZ:  begin o_cls.blez = 1'b1; o_aluc = ALUC_SUB; end
      OP_BGTZ:  begin o_cls.bgtz = 1'b1; o_aluc = ALUC_SUB; end
      OP_ADDI:  begin o_cls.alu_is = 1'b1; o_aluc = ALUC_ADD;  end
      OP_ADDIU: begin o_cls.alu_is = 1'b1; o_aluc = ALUC_ADDU; end
      OP_SLTI:  begin o_cls.alu_is = 1'b1; o_aluc = ALUC_SLT;  end
      OP_SLTIU: begin o_cls.alu_is = 1'b1; o_aluc = ALUC_SLTU; end
      OP_ANDI:  begin o_cls.alu_iz = 1'b1; o_aluc = ALUC_AND;  end
      OP_ORI:   begin o_cls.alu_iz = 1'b1; o_aluc = ALUC_OR;   end
      OP_XORI:  begin o_cls.alu_iz = 1'b1; o_aluc = ALUC_XOR;  end
      OP_LUI:   begin o_cls.alu_iz = 1'b1; o_aluc = ALUC_LUI;  end
      OP_LW:    o_cls.lw = 1'b1;
      OP_SW:    o_cls.sw = 1'b1;
      default:  o_cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mccu_fsm.sv
// Multicycle control FSM (IF/ID/EXE/MEM/WB). Outputs are combinational from
// the state register and the decode; every output is forced to 0 while rst=1.
module mccu_fsm
  import mccu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic [4:0] rt,
  input  logic       z,
  input  logic       n,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       wir,
  output logic       wpc,
  output logic       wtarget,
  output logic       wmem,
  output logic       wreg,
  output logic       regrt,
  output logic       jal,
  output logic       sext,
  output logic       m2reg,
  output logic       shift,
  output logic       cmpz,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [3:0] aluc,
  output logic       illegal,
  output logic [2:0] state
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  inst_cls_t  w_cls;
  logic [3:0] w_aluc;
  logic       w_branch;
  logic       w_taken;

  mccu_decode u_decode (
    .i_op   (op),
    .i_func (func),
    .i_rt   (rt),
    .o_cls  (w_cls),
    .o_aluc (w_aluc)
  );

  assign w_branch = w_cls.beq | w_cls.bne | w_cls.bgez | w_cls.bltz | w_cls.blez | w_cls.bgtz;
  assign w_taken  = (w_cls.beq  & z)       | (w_cls.bne  & ~z)
                  | (w_cls.bgez & ~n)      | (w_cls.bltz & n)
                  | (w_cls.blez & (z | n)) | (w_cls.bgtz & ~z & ~n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    wir      = 1'b0;
    wpc      = 1'b0;
    wtarget  = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    regrt    = 1'b0;
    jal      = 1'b0;
    sext     = 1'b0;
    m2reg    = 1'b0;
    shift    = 1'b0;
    cmpz     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsource = 2'b00;
    aluc     = ALUC_ADDU;
    illegal  = 1'b0;
    w_next   = S_IF;
    if (!rst) begin
      case (r_state)
        S_IF: begin
          mem_req = 1'b1;
          w_next  = S_IF;
          if (mem_ready) begin
            wir     = 1'b1;
            wpc     = 1'b1;
            alusrcb = 2'b01;
            aluc    = ALUC_ADD;
            w_next  = S_ID;
          end
        end
        S_ID: begin
          if (w_cls.illegal) begin
            illegal = 1'b1;
          end else begin
            wtarget = 1'b1;
            alusrcb = 2'b11;
            aluc    = ALUC_ADD;
            sext    = 1'b1;
            if (w_cls.j | w_cls.jal) begin
              wpc      = 1'b1;
              pcsource = 2'b11;
              wreg     = w_cls.jal;
              jal      = w_cls.jal;
            end else if (w_cls.jr | w_cls.jalr) begin
              wpc      = 1'b1;
              pcsource = 2'b10;
              wreg     = w_cls.jalr;
              jal      = w_cls.jalr;
            end else begin
              w_next = S_EXE;
            end
          end
        end
        S_EXE: begin
          alusrca = 1'b1;
          if (w_cls.lw | w_cls.sw) begin
            aluc    = ALUC_ADD;
            alusrcb = 2'b10;
            sext    = 1'b1;
            w_next  = S_MEM;
          end else if (w_branch) begin
            // Single-operand branches compare rs against a forced-zero B.
            aluc = ALUC_SUB;
            cmpz = ~(w_cls.beq | w_cls.bne);
            if (w_taken) begin
              wpc      = 1'b1;
              pcsource = 2'b01;
            end
          end else begin
            aluc    = w_aluc;
            shift   = w_cls.shift_r;
            alusrcb = (w_cls.alu_is | w_cls.alu_iz) ? 2'b10 : 2'b00;
            sext    = w_cls.alu_is;
            w_next  = S_WB;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          w_next  = S_MEM;
          if (mem_ready) begin
            wmem   = w_cls.sw;
            w_next = w_cls.sw ? S_IF : S_WB;
          end
        end
        S_WB: begin
          wreg   = 1'b1;
          regrt  = w_cls.alu_is | w_cls.alu_iz | w_cls.lw;
          m2reg  = w_cls.lw;
          w_next = S_IF;
        end
        default: w_next = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mccu_fsm.sv
// Directed self-checking bench for mccu_fsm with hand-computed expectations.
module tb_mccu_fsm;
  import mccu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, func;
  logic [4:0] rt;
  logic       z, n, mem_ready;
  logic       mem_req, iord, wir, wpc, wtarget, wmem, wreg;
  logic       regrt, jal, sext, m2reg, shift, cmpz, alusrca, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mccu_fsm dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .rt(rt), .z(z), .n(n),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .wir(wir), .wpc(wpc),
    .wtarget(wtarget), .wmem(wmem), .wreg(wreg), .regrt(regrt), .jal(jal),
    .sext(sext), .m2reg(m2reg), .shift(shift), .cmpz(cmpz), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsource(pcsource), .aluc(aluc), .illegal(illegal),
    .state(state)
  );

  function automatic logic [23:0] all_outs();
    return {mem_req, iord, wir, wpc, wtarget, wmem, wreg, regrt, jal, sext, m2reg,
            shift, cmpz, alusrca, alusrcb, pcsource, aluc, illegal};
  endfunction

  function automatic logic [4:0] strobes();
    return {wir, wpc, wtarget, wmem, wreg};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    op   = o;
    func = f;
    rt   = r;
  endtask

  task automatic run_branch(input string tag, input logic [5:0] o, input logic [4:0] r,
                            input logic zi, input logic ni, input logic taken,
                            input logic exp_cmpz);
    load(o, 6'd0, r);
    z = zi;
    n = ni;
    mem_ready = 1'b1;
    settle(); tick();
    settle(); tick();
    settle();
    check({tag, "_exe_state"}, 32'(state), 32'd2);
    check({tag, "_wpc"}, 32'(wpc), 32'(taken));
    check({tag, "_pcsource"}, 32'(pcsource), taken ? 32'd1 : 32'd0);
    check({tag, "_cmpz"}, 32'(cmpz), 32'(exp_cmpz));
    check({tag, "_aluc"}, 32'(aluc), 32'(ALUC_SUB));
    tick();
    settle();
    check({tag, "_back_if"}, 32'(state), 32'd0);
  endtask

  logic [2:0] lw_st [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4};
  logic       lw_rdy[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int wir_cnt;
    rst = 1'b1; mem_ready = 1'b1; z = 1'b0; n = 1'b0;
    load(OP_RTYPE, F_ADDU, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(all_outs()), 32'd0);
    rst = 1'b0;

    // addu, no wait states
    settle();
    check("addu_if_state", 32'(state), 32'd0);
    check("addu_if_fetch", 32'({mem_req, iord, wir, wpc}), 32'b1011);
    check("addu_if_alusrcb", 32'(alusrcb), 32'd1);
    check("addu_if_wreg", 32'(wreg), 32'd0);
    tick(); settle();
    check("addu_id_state", 32'(state), 32'd1);
    check("addu_id_wtarget", 32'(wtarget), 32'd1);
    check("addu_id_alusrcb", 32'(alusrcb), 32'd3);
    check("addu_id_wreg", 32'(wreg), 32'd0);
    tick(); settle();
    check("addu_exe_state", 32'(state), 32'd2);
    check("addu_exe_aluc", 32'(aluc), 32'd0);
    check("addu_exe_src", 32'({alusrca, alusrcb}), 32'b100);
    check("addu_exe_wreg", 32'(wreg), 32'd0);
    tick(); settle();
    check("addu_wb_state", 32'(state), 32'd4);
    check("addu_wb_wreg", 32'({wreg, regrt, m2reg}), 32'b100);
    tick(); settle();
    check("addu_done", 32'(state), 32'd0);

    // lw with wait states: 2 in IF, 1 in MEM
    load(OP_LW, 6'd0, 5'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(lw_st[i]);
    wir_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = lw_rdy[i];
      settle();
      check("lw_state", 32'(state), 32'(exp_q.pop_front()));
      wir_cnt += int'(wir);
      if (i == 0) check("lw_if_wait", 32'({mem_req, iord, wir, wpc}), 32'b1000);
      if (i == 4) check("lw_exe", 32'({aluc, alusrcb, sext}), 32'({ALUC_ADD, 2'b10, 1'b1}));
      if (i == 5) check("lw_mem_wait", 32'({mem_req, iord, wmem, wreg}), 32'b1100);
      if (i == 7) check("lw_wb", 32'({wreg, regrt, m2reg}), 32'b111);
      tick();
    end
    settle();
    check("lw_done", 32'(state), 32'd0);
    check("lw_wir_count", 32'(wir_cnt), 32'd1);

    run_branch("beq_t",  OP_BEQ,    5'd0,    1'b1, 1'b0, 1'b1, 1'b0);
    run_branch("beq_nt", OP_BEQ,    5'd0,    1'b0, 1'b0, 1'b0, 1'b0);
    run_branch("bgtz_t", OP_BGTZ,   5'd0,    1'b0, 1'b0, 1'b1, 1'b1);
    run_branch("blez_t", OP_BLEZ,   5'd0,    1'b0, 1'b1, 1'b1, 1'b1);
    run_branch("bltz_nt", OP_REGIMM, RT_BLTZ, 1'b0, 1'b0, 1'b0, 1'b1);
    z = 1'b0; n = 1'b0;

    // jal
    load(OP_JAL, 6'd0, 5'd0);
    mem_ready = 1'b1;
    settle(); tick(); settle();
    check("jal_id_state", 32'(state), 32'd1);
    check("jal_id_ctl", 32'({wpc, pcsource, wreg, jal}), 32'b11111);
    tick(); settle();
    check("jal_back_if", 32'(state), 32'd0);

    // illegal opcode
    load(6'b111111, 6'd0, 5'd0);
    settle(); tick(); settle();
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_strobes", 32'(strobes()), 32'd0);
    tick(); settle();
    check("ill_back_if", 32'(state), 32'd0);
    check("ill_cleared", 32'(illegal), 32'd0);

    // ori: zero-extended immediate, writes rt
    load(OP_ORI, 6'd0, 5'd0);
    settle(); tick(); settle(); tick(); settle();
    check("ori_exe", 32'({aluc, alusrcb, sext, shift}), 32'({ALUC_OR, 2'b10, 1'b0, 1'b0}));
    tick(); settle();
    check("ori_wb", 32'({wreg, regrt, m2reg}), 32'b110);
    tick();

    // sll: shamt as A operand
    load(OP_RTYPE, F_SLL, 5'd0);
    settle(); tick(); settle(); tick(); settle();
    check("sll_exe", 32'({aluc, shift, alusrcb}), 32'({ALUC_SLL, 1'b1, 2'b00}));
    tick(); tick();

    // sw, no wait states
    load(OP_SW, 6'd0, 5'd0);
    settle(); tick(); tick(); tick(); settle();
    check("sw_mem", 32'({state, mem_req, iord, wmem}), 32'({3'd3, 3'b111}));
    tick(); settle();
    check("sw_done", 32'(state), 32'd0);

    // sw with reset during MEM
    settle(); tick(); tick(); tick();
    mem_ready = 1'b0;
    settle();
    check("swr_mem_state", 32'(state), 32'd3);
    check("swr_mem_wmem", 32'(wmem), 32'd0);
    rst = 1'b1;
    mem_ready = 1'b1;
    settle();
    check("swr_rst_state", 32'(state), 32'd0);
    check("swr_rst_outs", 32'(all_outs()), 32'd0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    settle();
    check("swr_refetch", 32'({state, mem_req, wmem, wreg}), 32'({3'd0, 3'b100}));
    tick(); settle();
    check("swr_hold_if", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mccu_fsm.md
MCCU_FSM -- requirements
Module: mccu_fsm

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 op, func  in  6 each  opcode and function fields of the latched IR (stable from ID onward).
REQ-004 rt  in  5  IR rt field, decodes REGIMM bgez (00001) and bltz (00000).
REQ-005 z, n  in  1 each  ALU zero and negative flags for the current cycle.
REQ-006 mem_ready  in  1  memory done for the current request.
REQ-007 mem_req  out  1  memory access request; held until mem_ready.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-009 wir, wpc, wtarget  out  1 each  write enables for IR, PC and the branch-target register.
REQ-010 wmem, wreg  out  1 each  memory write and register-file write strobes.
REQ-011 regrt, jal, sext, m2reg, shift, cmpz  out  1 each  datapath selects: write rt, link $31, sign-extend, memory-to-register, shamt as A, force B=0.
REQ-012 alusrca  out  1  A operand: 0 = PC, 1 = rs.
REQ-013 alusrcb  out  2  B operand: 00 rt, 01 constant 4, 10 extended imm, 11 imm<<2.
REQ-014 pcsource  out  2  PC source: 00 ALU, 01 target register, 10 rs (jr/jalr), 11 jump address.
REQ-015 aluc  out  4  ALU operation code.
REQ-016 illegal  out  1  one-cycle pulse when an unsupported encoding is decoded.
REQ-017 state  out  3  current state, for debug.

Function
REQ-018 States: IF=0, ID=1, EXE=2, MEM=3, WB=4; encodings 5-7 go to IF on the next edge.
REQ-019 Supported instructions: add addu sub subu and or xor nor slt sltu sll srl sra sllv srlv srav jr jalr addi addiu andi ori xori lui slti sltiu lw sw beq bne bgez bltz blez bgtz j jal.
REQ-020 IF: mem_req=1, iord=0; while mem_ready=0 stay in IF with all strobes 0; when mem_ready=1, set wir=1, wpc=1, alusrca=0, alusrcb=01, aluc=ADD, pcsource=00, and go to ID.
REQ-021 ID: wtarget=1, alusrca=0, alusrcb=11, aluc=ADD, sext=1.
REQ-022 ID, j/jal: wpc=1, pcsource=11. jal also asserts wreg=1, jal=1. Next state IF.
REQ-023 ID, jr/jalr: wpc=1, pcsource=10. jalr also asserts wreg=1, jal=1 (rd target). Next state IF.
REQ-024 ID, illegal encoding: illegal=1 for one cycle, no write strobes, next state IF (NOP behaviour).
REQ-025 ID, all other instructions: next state EXE.
REQ-026 EXE, ALU instructions: alusrca=1 (shift=1 for sll/srl/sra); alusrcb=00 for R-type, 10 for I-type; aluc and sext per decode; next state WB.
REQ-027 EXE, lw/sw: aluc=ADD, alusrcb=10, sext=1; next state MEM.
REQ-028 EXE, branches: beq/bne use aluc=SUB with B=rt; bgez/bltz/blez/bgtz use aluc=SUB with cmpz=1.
REQ-029 Branch taken conditions: beq z; bne ~z; bgez ~n; bltz n; blez z|n; bgtz ~z&~n. When taken: wpc=1, pcsource=01. Next state IF in both cases.
REQ-030 MEM: mem_req=1, iord=1, wmem=1 for sw; wmem, like every strobe, is asserted only in the cycle where mem_ready=1. Then sw goes to IF and lw goes to WB.
REQ-031 WB: wreg=1; regrt=1 for I-type; m2reg=1 for lw; next state IF.
REQ-032 aluc constants: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 1000, SLTU 1010, SLT 1011, SRA 1100, SRL 1101, SLL 1110.
REQ-033 sext=0 for andi/ori/xori (zero-extend); lui uses alusrcb=10.
REQ-034 Latency with zero wait states: jump 2 cycles, branch 3, ALU and sw 4, lw 5; each mem_ready-low cycle adds one.
REQ-035 Outputs are combinational from state and decode. In each state, unlisted outputs are 0.

Reset
REQ-036 While rst=1: state=IF and every output is 0, including mem_req.
REQ-037 Reset asserted mid-MEM abandons the access with no wmem/wreg pulse; after release, fetch restarts in IF on the next edge.

Structure
REQ-038 Package mccu_pkg holds the state encodings, the aluc constants, and the opcode/func constants.
REQ-039 One sub-module, mccu_decode, is combinational: op/func/rt to one-hot instruction class plus aluc; the FSM instantiates it.

Verification
REQ-040 Reset, then addu with mem_ready=1 throughout: states 0,1,2,4,0; wreg=1 only in WB; aluc=0000 in EXE.
REQ-041 lw with mem_ready low for 2 cycles in IF and 1 cycle in MEM: 8 cycles total; m2reg=1, wreg=1 in WB; wir=1 exactly once.
REQ-042 beq with z=1: wpc=1, pcsource=01 in EXE. Same with z=0: wpc=0. Next state IF after 3 cycles in both cases.
REQ-043 bgtz with z=0, n=0: taken. blez with z=0, n=1: taken. bltz with n=0: not taken. cmpz=1 in EXE for all three.
REQ-044 jal: wpc=1, pcsource=11, wreg=1, jal=1 in ID; back in IF after 2 cycles.
REQ-045 Illegal op 111111: illegal pulse in ID, no strobes. Separately, rst asserted during MEM for sw: wmem never asserted and state=0.
